// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: line/word types, tag/offset split and victim cache FSM states.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_mem_data;

   localparam int OFFSET_W = 4;
   localparam int TAG_W    = 16 - OFFSET_W;

   typedef logic [TAG_W-1:0] lc3b_tag;

   typedef logic [2:0] vc_state_t;
   localparam vc_state_t S_IDLE      = 3'd0;
   localparam vc_state_t S_READ_HIT  = 3'd1;
   localparam vc_state_t S_FETCH     = 3'd2;
   localparam vc_state_t S_WRITEBACK = 3'd3;
   localparam vc_state_t S_INSERT    = 3'd4;

endpackage

// File: rtl/victim_cache_assoc_lru.sv
// Age-based LRU tracker for the victim cache: ages form a permutation, 0 = most recently used.
module victim_cache_assoc_lru #(
   parameter int NUM_ENTRIES = 4,
   localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_ENTRIES-1:0] valid,
   input  logic                   touch_en,
   input  logic [IDX_W-1:0]       touch_idx,
   input  logic                   inval_en,
   input  logic [IDX_W-1:0]       inval_idx,
   output logic [IDX_W-1:0]       victim_idx
);

   localparam logic [IDX_W-1:0] OLDEST = IDX_W'(NUM_ENTRIES - 1);

   logic [IDX_W-1:0] age [NUM_ENTRIES];

   // An invalidated entry is pushed to the oldest slot so it is reused first once the cache refills.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) age[i] <= IDX_W'(i);
      end else if (touch_en) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (IDX_W'(i) == touch_idx)        age[i] <= '0;
            else if (age[i] < age[touch_idx]) age[i] <= age[i] + IDX_W'(1);
         end
      end else if (inval_en) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (IDX_W'(i) == inval_idx)        age[i] <= OLDEST;
            else if (age[i] > age[inval_idx]) age[i] <= age[i] - IDX_W'(1);
         end
      end
   end

   // Lowest-index invalid entry wins; otherwise the oldest valid entry.
   always_comb begin
      victim_idx = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (age[i] == OLDEST) victim_idx = IDX_W'(i);
      end
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!valid[i]) victim_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/victim_cache_assoc.sv
// Fully-associative victim cache between an LC-3b L1 and physical memory, with exclusive swap on read hits.
module victim_cache_assoc
   import lc3b_types::*;
#(
   parameter int NUM_ENTRIES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  lc3b_word     mem_address,
   input  lc3b_mem_data mem_wdata,
   input  logic         l1_dirty,
   output logic         mem_resp,
   output lc3b_mem_data mem_rdata,
   output logic         dirty_out,
   output logic         ld_from_vic,
   output logic         pmem_read,
   output logic         pmem_write,
   output lc3b_word     pmem_address,
   output lc3b_mem_data pmem_wdata,
   input  lc3b_mem_data pmem_rdata,
   input  logic         pmem_resp
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);

   vc_state_t              state;
   logic [IDX_W-1:0]       sel_idx;
   logic                   was_hit;
   logic [NUM_ENTRIES-1:0] valid;
   logic [NUM_ENTRIES-1:0] dirty;
   lc3b_tag                tag_arr  [NUM_ENTRIES];
   lc3b_mem_data           data_arr [NUM_ENTRIES];

   lc3b_tag          req_tag;
   logic             hit;
   logic [IDX_W-1:0] hit_idx;
   logic [IDX_W-1:0] victim_idx;
   logic             victim_dirty;
   logic             unused_offset;

   assign req_tag       = mem_address[15:OFFSET_W];
   assign unused_offset = ^mem_address[OFFSET_W-1:0];
   assign victim_dirty  = valid[victim_idx] & dirty[victim_idx];

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (valid[i] && tag_arr[i] == req_tag) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   victim_cache_assoc_lru #(.NUM_ENTRIES(NUM_ENTRIES)) u_lru (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid      (valid),
      .touch_en   (state == S_INSERT),
      .touch_idx  (sel_idx),
      .inval_en   (state == S_READ_HIT),
      .inval_idx  (sel_idx),
      .victim_idx (victim_idx)
   );

   // The target entry is chosen once in IDLE and held in sel_idx for the rest of the transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         sel_idx <= '0;
         was_hit <= 1'b0;
         valid   <= '0;
         dirty   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (mem_read) begin
                  sel_idx <= hit_idx;
                  state   <= hit ? S_READ_HIT : S_FETCH;
               end else if (mem_write) begin
                  was_hit <= hit;
                  sel_idx <= hit ? hit_idx : victim_idx;
                  state   <= (!hit && victim_dirty) ? S_WRITEBACK : S_INSERT;
               end
            end
            S_READ_HIT: begin
               valid[sel_idx] <= 1'b0;
               dirty[sel_idx] <= 1'b0;
               state          <= S_IDLE;
            end
            S_FETCH: begin
               if (pmem_resp) state <= S_IDLE;
            end
            S_WRITEBACK: begin
               if (pmem_resp) state <= S_INSERT;
            end
            S_INSERT: begin
               valid[sel_idx] <= 1'b1;
               dirty[sel_idx] <= was_hit ? (dirty[sel_idx] | l1_dirty) : l1_dirty;
               state          <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_INSERT) begin
         tag_arr[sel_idx]  <= req_tag;
         data_arr[sel_idx] <= mem_wdata;
      end
   end

   always_comb begin
      mem_resp     = 1'b0;
      mem_rdata    = '0;
      dirty_out    = 1'b0;
      ld_from_vic  = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      case (state)
         S_READ_HIT: begin
            mem_resp    = 1'b1;
            ld_from_vic = 1'b1;
            mem_rdata   = data_arr[sel_idx];
            dirty_out   = dirty[sel_idx];
         end
         S_FETCH: begin
            pmem_read    = 1'b1;
            pmem_address = {req_tag, {OFFSET_W{1'b0}}};
            if (pmem_resp) begin
               mem_resp  = 1'b1;
               mem_rdata = pmem_rdata;
            end
         end
         S_WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_arr[sel_idx], {OFFSET_W{1'b0}}};
            pmem_wdata   = data_arr[sel_idx];
         end
         S_INSERT: mem_resp = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_victim_cache_assoc.sv
// Directed self-checking bench for victim_cache_assoc with NUM_ENTRIES=4.
module tb_victim_cache_assoc;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         mem_read = 1'b0;
   logic         mem_write = 1'b0;
   logic [15:0]  mem_address = '0;
   logic [127:0] mem_wdata = '0;
   logic         l1_dirty = 1'b0;
   logic         mem_resp;
   logic [127:0] mem_rdata;
   logic         dirty_out;
   logic         ld_from_vic;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata = '0;
   logic         pmem_resp = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   victim_cache_assoc #(.NUM_ENTRIES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .l1_dirty     (l1_dirty),
      .mem_resp     (mem_resp),
      .mem_rdata    (mem_rdata),
      .dirty_out    (dirty_out),
      .ld_from_vic  (ld_from_vic),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] line_data(input logic [15:0] addr, input logic [15:0] salt);
      return {8{addr ^ salt}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      pmem_resp = 1'b0;
      rst_n     = 1'b0;
      step();
      step();
      checkOutput("rst_mem_resp", mem_resp, 1'b0);
      checkOutput("rst_pmem_read", pmem_read, 1'b0);
      checkOutput("rst_pmem_write", pmem_write, 1'b0);
      checkOutput("rst_pmem_addr", pmem_address, 16'h0);
      checkOutput("rst_rdata", mem_rdata, 128'h0);
      checkOutput("rst_ld_from_vic", ld_from_vic, 1'b0);
      rst_n = 1'b1;
      step();
   endtask

   // Entered and left at posedge+1 with the FSM idle.
   task automatic applyWrite(input logic [15:0] addr, input logic [127:0] data, input logic dirty,
                             input logic exp_wb, input logic [15:0] wb_addr, input logic [127:0] wb_data);
      mem_address = addr;
      mem_wdata   = data;
      l1_dirty    = dirty;
      mem_write   = 1'b1;
      #1;
      checkOutput("wr_idle_no_resp", mem_resp, 1'b0);
      step();
      if (exp_wb) begin
         checkOutput("wb_pmem_write", pmem_write, 1'b1);
         checkOutput("wb_pmem_read", pmem_read, 1'b0);
         checkOutput("wb_addr", pmem_address, wb_addr);
         checkOutput("wb_data", pmem_wdata, wb_data);
         checkOutput("wb_no_resp", mem_resp, 1'b0);
         step();
         checkOutput("wb_held", pmem_write, 1'b1);
         pmem_resp = 1'b1;
         step();
         pmem_resp = 1'b0;
      end
      checkOutput("ins_resp", mem_resp, 1'b1);
      checkOutput("ins_no_pmem_write", pmem_write, 1'b0);
      checkOutput("ins_no_pmem_read", pmem_read, 1'b0);
      mem_write = 1'b0;
      step();
      checkOutput("ins_resp_drop", mem_resp, 1'b0);
   endtask

   task automatic applyRead(input logic [15:0] addr, input logic exp_hit, input logic [127:0] exp_data,
                            input logic exp_dirty, input logic [127:0] mem_data);
      mem_address = addr;
      mem_read    = 1'b1;
      step();
      if (exp_hit) begin
         checkOutput("hit_resp", mem_resp, 1'b1);
         checkOutput("hit_ld_from_vic", ld_from_vic, 1'b1);
         checkOutput("hit_data", mem_rdata, exp_data);
         checkOutput("hit_dirty", dirty_out, exp_dirty);
         checkOutput("hit_no_pmem_read", pmem_read, 1'b0);
         mem_read = 1'b0;
         step();
      end else begin
         checkOutput("miss_pmem_read", pmem_read, 1'b1);
         checkOutput("miss_pmem_write", pmem_write, 1'b0);
         checkOutput("miss_addr", pmem_address, {addr[15:4], 4'h0});
         checkOutput("miss_no_resp", mem_resp, 1'b0);
         pmem_rdata = mem_data;
         pmem_resp  = 1'b1;
         #1;
         checkOutput("fetch_resp", mem_resp, 1'b1);
         checkOutput("fetch_data", mem_rdata, mem_data);
         checkOutput("fetch_ld_from_vic", ld_from_vic, 1'b0);
         checkOutput("fetch_dirty", dirty_out, 1'b0);
         @(posedge clk);
         #1;
         pmem_resp = 1'b0;
         mem_read  = 1'b0;
      end
      checkOutput("rd_resp_drop", mem_resp, 1'b0);
   endtask

   initial begin
      applyReset();

      $display("[TB] clean insert then read hit with offset");
      applyWrite(16'h1230, line_data(16'h1230, 16'h0001), 1'b0, 1'b0, 16'h0, 128'h0);
      applyRead(16'h1238, 1'b1, line_data(16'h1230, 16'h0001), 1'b0, 128'h0);
      applyRead(16'h1230, 1'b0, 128'h0, 1'b0, line_data(16'h1230, 16'hBEEF));

      $display("[TB] miss on empty cache");
      applyRead(16'h7770, 1'b0, 128'h0, 1'b0, line_data(16'h7770, 16'h5A5A));

      $display("[TB] write hit merges dirty and replaces data");
      applyWrite(16'h1000, line_data(16'h1000, 16'h0011), 1'b1, 1'b0, 16'h0, 128'h0);
      applyWrite(16'h1000, line_data(16'h1000, 16'h0022), 1'b0, 1'b0, 16'h0, 128'h0);
      applyRead(16'h1000, 1'b1, line_data(16'h1000, 16'h0022), 1'b1, 128'h0);

      $display("[TB] full dirty cache evicts oldest");
      applyReset();
      for (int i = 1; i <= 4; i++) begin
         applyWrite(16'(i) << 12, line_data(16'(i) << 12, 16'h0100), 1'b1, 1'b0, 16'h0, 128'h0);
      end
      applyWrite(16'h5000, line_data(16'h5000, 16'h0100), 1'b1, 1'b1, 16'h1000, line_data(16'h1000, 16'h0100));
      applyWrite(16'h6000, line_data(16'h6000, 16'h0100), 1'b1, 1'b1, 16'h2000, line_data(16'h2000, 16'h0100));
      applyRead(16'h5000, 1'b1, line_data(16'h5000, 16'h0100), 1'b1, 128'h0);

      $display("[TB] touching an entry protects it from eviction");
      applyReset();
      for (int i = 1; i <= 4; i++) begin
         applyWrite(16'(i) << 12, line_data(16'(i) << 12, 16'h0200), 1'b1, 1'b0, 16'h0, 128'h0);
      end
      applyWrite(16'h1000, line_data(16'h1000, 16'h0300), 1'b0, 1'b0, 16'h0, 128'h0);
      applyWrite(16'h6000, line_data(16'h6000, 16'h0200), 1'b0, 1'b1, 16'h2000, line_data(16'h2000, 16'h0200));
      applyRead(16'h6000, 1'b1, line_data(16'h6000, 16'h0200), 1'b0, 128'h0);
      applyRead(16'h1000, 1'b1, line_data(16'h1000, 16'h0300), 1'b1, 128'h0);

      $display("[TB] reset during writeback");
      applyReset();
      for (int i = 1; i <= 4; i++) begin
         applyWrite(16'(i) << 12, line_data(16'(i) << 12, 16'h0400), 1'b1, 1'b0, 16'h0, 128'h0);
      end
      mem_address = 16'h5000;
      mem_wdata   = line_data(16'h5000, 16'h0400);
      l1_dirty    = 1'b1;
      mem_write   = 1'b1;
      step();
      checkOutput("abort_wb_active", pmem_write, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_pmem_write_drop", pmem_write, 1'b0);
      checkOutput("abort_no_resp", mem_resp, 1'b0);
      mem_write = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checkOutput("abort_rst_no_resp", mem_resp, 1'b0);
      end
      rst_n = 1'b1;
      step();
      checkOutput("abort_post_no_resp", mem_resp, 1'b0);
      applyRead(16'h1000, 1'b0, 128'h0, 1'b0, line_data(16'h1000, 16'h7777));
      applyRead(16'h4000, 1'b0, 128'h0, 1'b0, line_data(16'h4000, 16'h7777));

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
